// File: rtl/dcache_arb_pkg.sv
// Shared types and constants for the data-cache port arbiter.
// FSM state encoding, grant identifiers and request-tag opcode fields.
package dcache_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        DATA      = 3'd2,
        WAIT_RESP = 3'd3,
        RESP_HOLD = 3'd4
    } arb_state_t;

    localparam logic GRANT_LD = 1'b0;
    localparam logic GRANT_ST = 1'b1;

    // Opcode bits carried in the request tag; the arbiter forwards tags untouched.
    localparam int unsigned TAG_FIELD_W = 13;
    localparam logic [TAG_FIELD_W-1:0] READ   = 13'h0001;
    localparam logic [TAG_FIELD_W-1:0] WRITE  = 13'h0002;
    localparam logic [TAG_FIELD_W-1:0] MEMORY = 13'h0010;

endpackage

// File: rtl/dcache_arb_pick.sv
// Winner selection between the load and store ports.
// Fixed store priority by default; round-robin on ties with ARB_ROUND_ROBIN_EN.
module dcache_arb_pick
    import dcache_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic reset,
    input  logic i_grant_en,
`endif
    input  logic i_ld_req,
    input  logic i_st_req,
    output logic o_valid,
    output logic o_grant_id
);

    assign o_valid = i_ld_req | i_st_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Holds the port granted last; reset value of load hands the first tie to store.
    logic r_last_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_id <= GRANT_LD;
        end else if (i_grant_en) begin
            r_last_id <= o_grant_id;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        o_grant_id = GRANT_LD;
        if (i_ld_req && i_st_req) begin
            o_grant_id = ~r_last_id;
        end else if (i_st_req) begin
            o_grant_id = GRANT_ST;
        end
    end
`else
    always_comb begin
        o_grant_id = GRANT_LD;
        if (i_st_req) begin
            o_grant_id = GRANT_ST;
        end
    end
`endif

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates one load and one store port onto a single cache request/response bus.
// One transaction outstanding; define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ld_reqcyc,
    input  logic [DATA_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    output logic              ld_reqack,
    output logic              ld_respcyc,
    output logic [DATA_W-1:0] ld_resp,
    input  logic              ld_respack,

    input  logic              st_reqcyc,
    input  logic [DATA_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [TAG_W-1:0]  st_tag,
    output logic              st_reqack,
    output logic              st_done,

    output logic              bus_reqcyc,
    output logic [DATA_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    output logic              bus_respack,

    output logic              busy,
    output logic              grant_id
);

    arb_state_t        r_state;
    logic [DATA_W-1:0] r_data;
    logic              r_gap;

    logic              w_pick_valid;
    logic              w_pick_id;
    logic              w_grant;

    // r_gap marks the first IDLE cycle after a transaction, which never grants.
    assign w_grant = (r_state == IDLE) && !r_gap && w_pick_valid;
    assign busy    = (r_state != IDLE);

    dcache_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .clk        (clk),
        .reset      (reset),
        .i_grant_en (w_grant),
`endif
        .i_ld_req   (ld_reqcyc),
        .i_st_req   (st_reqcyc),
        .o_valid    (w_pick_valid),
        .o_grant_id (w_pick_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_gap       <= 1'b0;
            ld_reqack   <= 1'b0;
            st_reqack   <= 1'b0;
            st_done     <= 1'b0;
            ld_respcyc  <= 1'b0;
            ld_resp     <= '0;
            bus_reqcyc  <= 1'b0;
            bus_req     <= '0;
            bus_reqtag  <= '0;
            bus_respack <= 1'b0;
            grant_id    <= GRANT_LD;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            ld_reqack   <= 1'b0;
            st_reqack   <= 1'b0;
            st_done     <= 1'b0;
            bus_respack <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_gap <= 1'b0;
                    if (w_grant) begin
                        r_state    <= ADDR;
                        grant_id   <= w_pick_id;
                        bus_reqcyc <= 1'b1;
                        if (w_pick_id == GRANT_ST) begin
                            st_reqack  <= 1'b1;
                            bus_req    <= st_addr;
                            bus_reqtag <= st_tag;
                            r_data     <= st_data;
                        end else begin
                            ld_reqack  <= 1'b1;
                            bus_req    <= ld_addr;
                            bus_reqtag <= ld_tag;
                        end
                    end
                end

                ADDR: begin
                    if (bus_reqack) begin
                        if (grant_id == GRANT_ST) begin
                            r_state <= DATA;
                            bus_req <= r_data;
                        end else begin
                            r_state    <= WAIT_RESP;
                            bus_reqcyc <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (bus_reqack) begin
                        r_state    <= IDLE;
                        r_gap      <= 1'b1;
                        bus_reqcyc <= 1'b0;
                        st_done    <= 1'b1;
                    end
                end

                WAIT_RESP: begin
                    if (bus_respcyc) begin
                        r_state     <= RESP_HOLD;
                        ld_resp     <= bus_resp;
                        ld_respcyc  <= 1'b1;
                        bus_respack <= 1'b1;
                    end
                end

                RESP_HOLD: begin
                    if (ld_respack) begin
                        r_state    <= IDLE;
                        r_gap      <= 1'b1;
                        ld_respcyc <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed, table-driven bench for dcache_port_arbiter plus hand-written corner sequences.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_dcache_port_arbiter;
    import dcache_arb_pkg::*;

    localparam logic [63:0] LA  = 64'h1000;
    localparam logic [63:0] SA  = 64'h2000;
    localparam logic [63:0] SD  = 64'h55;
    localparam logic [63:0] R1  = 64'hDEADBEEF;
    localparam logic [63:0] R2  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] R3  = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] BAD = 64'h0BAD_0BAD;
    localparam logic [12:0] LD_TAG = READ | MEMORY;
    localparam logic [12:0] ST_TAG = WRITE | MEMORY;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_reqcyc, ld_reqack, ld_respcyc, ld_respack;
    logic [63:0] ld_addr, ld_resp;
    logic [12:0] ld_tag, st_tag, bus_reqtag;
    logic        st_reqcyc, st_reqack, st_done;
    logic [63:0] st_addr, st_data;
    logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [63:0] bus_req, bus_resp;
    logic        busy, grant_id;

    int n_chk = 0;
    int n_err = 0;

    dcache_port_arbiter #(.DATA_W(64), .TAG_W(13)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_reqcyc   (ld_reqcyc),
        .ld_addr     (ld_addr),
        .ld_tag      (ld_tag),
        .ld_reqack   (ld_reqack),
        .ld_respcyc  (ld_respcyc),
        .ld_resp     (ld_resp),
        .ld_respack  (ld_respack),
        .st_reqcyc   (st_reqcyc),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_tag      (st_tag),
        .st_reqack   (st_reqack),
        .st_done     (st_done),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_respack (bus_respack),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    // in:  {reset, ld_reqcyc, st_reqcyc, bus_reqack, bus_respcyc, ld_respack}
    // ex:  {ld_reqack, st_reqack, st_done, bus_reqcyc, bus_respack, ld_respcyc, busy, grant_id}
    typedef struct {
        logic [5:0]  in;
        logic [63:0] resp;
        logic [7:0]  ex;
        logic [63:0] breq;
        logic [63:0] lresp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] in, input logic [63:0] resp,
                                input logic [7:0] ex, input logic [63:0] breq,
                                input logic [63:0] lresp);
        vec_t v;
        v.in = in; v.resp = resp; v.ex = ex; v.breq = breq; v.lresp = lresp;
        return v;
    endfunction

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        string       names[8];
        logic [7:0]  act;
        bit          got;

        names = '{"ld_reqack", "st_reqack", "st_done", "bus_reqcyc",
                  "bus_respack", "ld_respcyc", "busy", "grant_id"};

        reset = 1'b1; ld_reqcyc = 0; st_reqcyc = 0; bus_reqack = 0; bus_respcyc = 0; ld_respack = 0;
        ld_addr = LA; ld_tag = LD_TAG; st_addr = SA; st_data = SD; st_tag = ST_TAG; bus_resp = '0;

        // Reset, then load with bus_reqack on the second ADDR cycle.
        vecs.push_back(mk(6'b100000, 0,   8'b00000000, 0,  0));
        vecs.push_back(mk(6'b010000, 0,   8'b10010010, LA, 0));
        vecs.push_back(mk(6'b000000, 0,   8'b00010010, LA, 0));
        vecs.push_back(mk(6'b000100, 0,   8'b00000010, LA, 0));
        vecs.push_back(mk(6'b000010, R1,  8'b00001110, LA, R1));
        vecs.push_back(mk(6'b000001, 0,   8'b00000000, LA, R1));
        vecs.push_back(mk(6'b000000, 0,   8'b00000000, LA, R1));
        // Store: address beat then data beat, st_done on return to IDLE.
        vecs.push_back(mk(6'b001000, 0,   8'b01010011, SA, R1));
        vecs.push_back(mk(6'b000100, 0,   8'b00010011, SD, R1));
        vecs.push_back(mk(6'b000100, 0,   8'b00100001, SD, R1));
        vecs.push_back(mk(6'b000000, 0,   8'b00000001, SD, R1));
        // Stray bus_respcyc in IDLE and in DATA.
        vecs.push_back(mk(6'b000010, BAD, 8'b00000001, SD, R1));
        vecs.push_back(mk(6'b001000, 0,   8'b01010011, SA, R1));
        vecs.push_back(mk(6'b000100, 0,   8'b00010011, SD, R1));
        vecs.push_back(mk(6'b000010, BAD, 8'b00010011, SD, R1));
        vecs.push_back(mk(6'b000100, 0,   8'b00100001, SD, R1));
        vecs.push_back(mk(6'b000000, 0,   8'b00000001, SD, R1));
        // Two back-to-back ties after reset; second grant depends on arbitration mode.
        vecs.push_back(mk(6'b100000, 0,   8'b00000000, 0,  0));
        vecs.push_back(mk(6'b011000, 0,   8'b01010011, SA, 0));
        vecs.push_back(mk(6'b010100, 0,   8'b00010011, SD, 0));
        vecs.push_back(mk(6'b010100, 0,   8'b00100001, SD, 0));
        vecs.push_back(mk(6'b011000, 0,   8'b00000001, SD, 0));
`ifdef ARB_ROUND_ROBIN_EN
        vecs.push_back(mk(6'b011000, 0,   8'b10010010, LA, 0));
`else
        vecs.push_back(mk(6'b011000, 0,   8'b01010011, SA, 0));
`endif
        // Reset mid-transaction, reset in WAIT_RESP, late response, then a clean load.
        vecs.push_back(mk(6'b100000, 0,   8'b00000000, 0,  0));
        vecs.push_back(mk(6'b010000, 0,   8'b10010010, LA, 0));
        vecs.push_back(mk(6'b000100, 0,   8'b00000010, LA, 0));
        vecs.push_back(mk(6'b100000, 0,   8'b00000000, 0,  0));
        vecs.push_back(mk(6'b000010, BAD, 8'b00000000, 0,  0));
        vecs.push_back(mk(6'b010000, 0,   8'b10010010, LA, 0));
        vecs.push_back(mk(6'b000100, 0,   8'b00000010, LA, 0));
        vecs.push_back(mk(6'b000010, R2,  8'b00001110, LA, R2));
        vecs.push_back(mk(6'b000001, 0,   8'b00000000, LA, R2));

        #2;
        foreach (vecs[i]) begin
            {reset, ld_reqcyc, st_reqcyc, bus_reqack, bus_respcyc, ld_respack} = vecs[i].in;
            bus_resp = vecs[i].resp;
            step();
            act = {ld_reqack, st_reqack, st_done, bus_reqcyc, bus_respack, ld_respcyc, busy, grant_id};
            for (int b = 0; b < 8; b++) begin
                check($sformatf("row%0d %s", i, names[b]), 64'(act[7-b]), 64'(vecs[i].ex[7-b]));
            end
            check($sformatf("row%0d bus_req", i), bus_req, vecs[i].breq);
            check($sformatf("row%0d ld_resp", i), ld_resp, vecs[i].lresp);
        end

        // Held response with a pending store: store waits for RESP_HOLD exit plus the IDLE gap.
        {reset, ld_reqcyc, st_reqcyc, bus_reqack, bus_respcyc, ld_respack} = 6'b100000;
        step();
        reset = 1'b0;
        ld_reqcyc = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = ld_reqack;
        end
        check("seq load grant", 64'(got), 64'(1));
        check("seq load tag", 64'(bus_reqtag), 64'(LD_TAG));
        check("seq load bus_req", bus_req, LA);

        ld_reqcyc = 1'b0; st_reqcyc = 1'b1; bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        check("seq wait st_reqack", 64'(st_reqack), 64'(0));
        check("seq wait bus_reqcyc", 64'(bus_reqcyc), 64'(0));

        bus_respcyc = 1'b1; bus_resp = R3;
        step();
        bus_respcyc = 1'b0; bus_resp = BAD;
        check("seq hold ld_respcyc", 64'(ld_respcyc), 64'(1));
        check("seq hold bus_respack", 64'(bus_respack), 64'(1));
        check("seq hold ld_resp", ld_resp, R3);

        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("seq held%0d ld_respcyc", k), 64'(ld_respcyc), 64'(1));
            check($sformatf("seq held%0d ld_resp", k), ld_resp, R3);
            check($sformatf("seq held%0d bus_respack", k), 64'(bus_respack), 64'(0));
            check($sformatf("seq held%0d st_reqack", k), 64'(st_reqack), 64'(0));
        end

        ld_respack = 1'b1;
        step();
        ld_respack = 1'b0;
        check("seq release ld_respcyc", 64'(ld_respcyc), 64'(0));
        check("seq release busy", 64'(busy), 64'(0));
        check("seq release st_reqack", 64'(st_reqack), 64'(0));

        step();
        check("seq gap st_reqack", 64'(st_reqack), 64'(0));
        check("seq gap busy", 64'(busy), 64'(0));

        step();
        check("seq store grant st_reqack", 64'(st_reqack), 64'(1));
        check("seq store grant_id", 64'(grant_id), 64'(GRANT_ST));
        check("seq store bus_req", bus_req, SA);
        check("seq store tag", 64'(bus_reqtag), 64'(ST_TAG));

        st_reqcyc = 1'b0; bus_reqack = 1'b1;
        step();
        check("seq store data beat", bus_req, SD);
        check("seq store no done yet", 64'(st_done), 64'(0));
        step();
        bus_reqack = 1'b0;
        check("seq store st_done", 64'(st_done), 64'(1));
        check("seq store bus_reqcyc", 64'(bus_reqcyc), 64'(0));
        step();
        check("seq store st_done pulse", 64'(st_done), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
